// File: rtl/mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// mul_arb_pkg
// Shared definitions for the multiplier arbiter:
//   - default values for the requester count, datapath width and multiplier
//     latency
//   - the two arbiter states (IDLE, BUSY), held as plain logic constants so
//     older tools and scripts can still match the encoding
//   - cnt_width(), which sizes the latency counter so it can hold MUL_LAT
// No ports; imported by rr_select and mul_arbiter.
// ---------------------------------------------------------------------------
package mul_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 16;
   localparam int MUL_LAT_DEF = 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // The counter is loaded with MUL_LAT and counts down to 1, so it needs
   // enough bits to represent MUL_LAT itself.
   function automatic int cnt_width(input int mul_lat);
      return $clog2(mul_lat + 1);
   endfunction

endpackage

// File: rtl/mul_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker. Starting at ptr and searching upward
// with wrap-around, it selects the first requester whose req bit is set.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  PTR_W    highest-priority requester index for this pick
//   win_onehot out NUM_REQ  one-hot winner (all zero when req is zero)
//   win_idx    out PTR_W    index of the winner (zero when none)
//   win_valid  out 1        a winner exists
// ---------------------------------------------------------------------------
module rr_select
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [PTR_W-1:0]   win_idx,
   output logic               win_valid
);

   // Walk the requesters in priority order (ptr, ptr+1, ... wrapping) and
   // latch onto the first active one; later hits are ignored once a winner
   // has been found.
   always_comb begin
      logic [PTR_W-1:0] idx;
      win_onehot = '0;
      win_idx    = '0;
      win_valid  = 1'b0;
      idx        = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
         if (!win_valid && req[idx]) begin
            win_valid       = 1'b1;
            win_onehot[idx] = 1'b1;
            win_idx         = idx;
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one multiplier between NUM_REQ requesters. A round-robin winner is
// granted, its operands are registered onto mul_a/mul_b, and after MUL_LAT
// cycles the low DATA_W bits of mul_p are captured into result while done
// pulses for one cycle on the winner's bit. One operation is in flight at a
// time; req is ignored while busy.
// Ports:
//   CLOCK_50  in  1            system clock
//   reset     in  1            synchronous, active-high reset
//   req       in  NUM_REQ      per-requester request (held until done)
//   op_a      in  NUM_REQ*W    packed first operands, slice i*W +: W
//   op_b      in  NUM_REQ*W    packed second operands
//   grant     out NUM_REQ      one-hot, requester currently being served
//   done      out NUM_REQ      one-hot single-cycle completion pulse
//   result    out W            low half of the product, held until next capture
//   result_hi out W            high half of the product (MUL_ARB_HIGH_WORD_EN only)
//   busy      out 1            operation in flight
//   mul_a     out W            registered multiplier operand A
//   mul_b     out W            registered multiplier operand B
//   mul_p     in  2*W          multiplier product
// Build option: define MUL_ARB_HIGH_WORD_EN to add the result_hi output.
// ---------------------------------------------------------------------------
module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] op_a,
   input  logic [NUM_REQ*DATA_W-1:0] op_b,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         result,
`ifdef MUL_ARB_HIGH_WORD_EN
   output logic [DATA_W-1:0]         result_hi,
`endif
   output logic                      busy,
   output logic [DATA_W-1:0]         mul_a,
   output logic [DATA_W-1:0]         mul_b,
   input  logic [2*DATA_W-1:0]       mul_p
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = cnt_width(MUL_LAT);

   logic [0:0]         state_q,  state_d;
   logic [PTR_W-1:0]   ptr_q,    ptr_d;
   logic [PTR_W-1:0]   gidx_q,   gidx_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [NUM_REQ-1:0] grant_q,  grant_d;
   logic [NUM_REQ-1:0] done_q,   done_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               busy_q,   busy_d;
   logic [DATA_W-1:0]  mul_a_q,  mul_a_d;
   logic [DATA_W-1:0]  mul_b_q,  mul_b_d;

   logic [NUM_REQ-1:0] win_onehot;
   logic [PTR_W-1:0]   win_idx;
   logic               win_valid;

`ifdef MUL_ARB_HIGH_WORD_EN
   logic [DATA_W-1:0]  result_hi_q, result_hi_d;
`else
   // Upper product bits are deliberately dropped in this build.
   logic unused_mul_p_hi;
   assign unused_mul_p_hi = ^mul_p[2*DATA_W-1:DATA_W];
`endif

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_select (
      .req        (req),
      .ptr        (ptr_q),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .win_valid  (win_valid)
   );

   // Next-state logic. Everything holds by default; done is a pulse and so
   // defaults to zero. In IDLE a winner is launched onto the multiplier; in
   // BUSY the counter runs down and on its last count the product is
   // captured, done fires and the pointer moves past the served requester.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gidx_d   = gidx_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      done_d   = '0;
      result_d = result_q;
      busy_d   = busy_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
`ifdef MUL_ARB_HIGH_WORD_EN
      result_hi_d = result_hi_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d = ST_BUSY;
               grant_d = win_onehot;
               gidx_d  = win_idx;
               mul_a_d = op_a[int'(win_idx)*DATA_W +: DATA_W];
               mul_b_d = op_b[int'(win_idx)*DATA_W +: DATA_W];
               cnt_d   = CNT_W'(MUL_LAT);
               busy_d  = 1'b1;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_IDLE;
               result_d = mul_p[DATA_W-1:0];
`ifdef MUL_ARB_HIGH_WORD_EN
               result_hi_d = mul_p[2*DATA_W-1:DATA_W];
`endif
               done_d   = grant_q;
               grant_d  = '0;
               busy_d   = 1'b0;
               if (gidx_q == PTR_W'(NUM_REQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = gidx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset drops any in-flight operation without a done.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         gidx_q   <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
`ifdef MUL_ARB_HIGH_WORD_EN
         result_hi_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gidx_q   <= gidx_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
`ifdef MUL_ARB_HIGH_WORD_EN
         result_hi_q <= result_hi_d;
`endif
      end
   end

   assign grant  = grant_q;
   assign done   = done_q;
   assign result = result_q;
   assign busy   = busy_q;
   assign mul_a  = mul_a_q;
   assign mul_b  = mul_b_q;
`ifdef MUL_ARB_HIGH_WORD_EN
   assign result_hi = result_hi_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Directed bench for mul_arbiter. Three instances share the clock and the
// operand buses: u_a (MUL_LAT=1) for basic service, ordering, overflow and
// operand sampling; u_b (MUL_LAT=3) for reset during an operation; u_c
// (MUL_LAT=4) for latency and busy duration. Each instance gets an ideal
// combinational multiplier driven from its own mul_a/mul_b.
// Build option: MUL_ARB_HIGH_WORD_EN also connects and checks result_hi.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

   logic        clk;
   logic [63:0] opa, opb;

   logic        rst_a, rst_b, rst_c;
   logic [3:0]  req_a, req_b, req_c;
   logic [3:0]  grant_a, grant_b, grant_c;
   logic [3:0]  done_a, done_b, done_c;
   logic [15:0] result_a, result_b, result_c;
   logic        busy_a, busy_b, busy_c;
   logic [15:0] mul_a_a, mul_a_b, mul_a_c;
   logic [15:0] mul_b_a, mul_b_b, mul_b_c;
   logic [31:0] mul_p_a, mul_p_b, mul_p_c;
`ifdef MUL_ARB_HIGH_WORD_EN
   logic [15:0] result_hi_a, result_hi_b, result_hi_c;
`endif

   int checks;
   int errors;

   assign mul_p_a = mul_a_a * mul_b_a;
   assign mul_p_b = mul_a_b * mul_b_b;
   assign mul_p_c = mul_a_c * mul_b_c;

   mul_arbiter #(.NUM_REQ(4), .DATA_W(16), .MUL_LAT(1)) u_a (
      .CLOCK_50(clk), .reset(rst_a), .req(req_a), .op_a(opa), .op_b(opb),
      .grant(grant_a), .done(done_a), .result(result_a),
`ifdef MUL_ARB_HIGH_WORD_EN
      .result_hi(result_hi_a),
`endif
      .busy(busy_a), .mul_a(mul_a_a), .mul_b(mul_b_a), .mul_p(mul_p_a)
   );

   mul_arbiter #(.NUM_REQ(4), .DATA_W(16), .MUL_LAT(3)) u_b (
      .CLOCK_50(clk), .reset(rst_b), .req(req_b), .op_a(opa), .op_b(opb),
      .grant(grant_b), .done(done_b), .result(result_b),
`ifdef MUL_ARB_HIGH_WORD_EN
      .result_hi(result_hi_b),
`endif
      .busy(busy_b), .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_p(mul_p_b)
   );

   mul_arbiter #(.NUM_REQ(4), .DATA_W(16), .MUL_LAT(4)) u_c (
      .CLOCK_50(clk), .reset(rst_c), .req(req_c), .op_a(opa), .op_b(opb),
      .grant(grant_c), .done(done_c), .result(result_c),
`ifdef MUL_ARB_HIGH_WORD_EN
      .result_hi(result_hi_c),
`endif
      .busy(busy_c), .mul_a(mul_a_c), .mul_b(mul_b_c), .mul_p(mul_p_c)
   );

   // 50 MHz clock
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Hard stop in case something stalls the main sequence
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if it does not match
   task automatic checkOutput(input string tag, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive the request vector of one instance (0=u_a, 1=u_b, 2=u_c)
   task automatic applyStimulus(input int inst, input logic [3:0] r);
      case (inst)
         0:       req_a = r;
         1:       req_b = r;
         default: req_c = r;
      endcase
   endtask

   // Load the operands of one requester on the shared buses
   task automatic setOp(input int i, input logic [15:0] a, input logic [15:0] b);
      opa[i*16 +: 16] = a;
      opb[i*16 +: 16] = b;
   endtask

   // Main directed sequence; all driving happens on the falling edge
   initial begin
      int          order [5];
      logic [15:0] prod  [4];
      logic [3:0]  done_seen;
      int          g_cyc, d_cyc, busy_n;
      logic [3:0]  gsel, dsel;
      logic [15:0] res_c;

      order = '{0, 1, 2, 3, 0};
      prod  = '{16'd18, 16'd60000, 16'h2468, 16'd65000};

      checks = 0;
      errors = 0;
      opa = '0;
      opb = '0;
      req_a = '0; req_b = '0; req_c = '0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      @(negedge clk);

      // Reset values
      checkOutput("rst_grant",  grant_a,  32'h0);
      checkOutput("rst_done",   done_a,   32'h0);
      checkOutput("rst_result", result_a, 32'h0);
      checkOutput("rst_busy",   busy_a,   32'h0);
      checkOutput("rst_mul_a",  mul_a_a,  32'h0);
      checkOutput("rst_mul_b",  mul_b_a,  32'h0);

      // Single request: 3*7
      setOp(0, 16'd3, 16'd7);
      applyStimulus(0, 4'b0001);
      @(negedge clk);
      checkOutput("t1_grant", grant_a, 32'h1);
      checkOutput("t1_busy",  busy_a,  32'h1);
      checkOutput("t1_mul_a", mul_a_a, 32'd3);
      checkOutput("t1_mul_b", mul_b_a, 32'd7);
      checkOutput("t1_nodone", done_a, 32'h0);
      @(negedge clk);
      checkOutput("t1_done",   done_a,   32'h1);
      checkOutput("t1_result", result_a, 32'd21);
      checkOutput("t1_busy0",  busy_a,   32'h0);
      checkOutput("t1_grant0", grant_a,  32'h0);
      applyStimulus(0, 4'b0000);
      @(negedge clk);
      checkOutput("t1_pulse",  done_a,   32'h0);
      checkOutput("t1_hold",   result_a, 32'd21);

      // All four requesting continuously, starting from a fresh pointer
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      setOp(0, 16'd2,     16'd9);
      setOp(1, 16'd300,   16'd200);
      setOp(2, 16'h1234,  16'd2);
      setOp(3, 16'd1000,  16'd65);
      applyStimulus(0, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t2_grant%0d", k), grant_a, 32'(4'b0001 << order[k]));
         @(negedge clk);
         checkOutput($sformatf("t2_done%0d", k), done_a, 32'(4'b0001 << order[k]));
         checkOutput($sformatf("t2_result%0d", k), result_a, 32'(prod[order[k]]));
      end
      applyStimulus(0, 4'b0000);

      // Overflow: 0xFFFF*0xFFFF = 0xFFFE0001
      setOp(1, 16'hFFFF, 16'hFFFF);
      applyStimulus(0, 4'b0010);
      @(negedge clk);
      checkOutput("t3_grant", grant_a, 32'h2);
      @(negedge clk);
      checkOutput("t3_done",   done_a,   32'h2);
      checkOutput("t3_result", result_a, 32'h0001);
`ifdef MUL_ARB_HIGH_WORD_EN
      checkOutput("t3_result_hi", result_hi_a, 32'hFFFE);
`endif
      applyStimulus(0, 4'b0000);

      // Requester 2 drops req and changes op_a after the grant edge
      setOp(2, 16'd11, 16'd13);
      applyStimulus(0, 4'b0100);
      @(negedge clk);
      checkOutput("t4_grant", grant_a, 32'h4);
      applyStimulus(0, 4'b0000);
      setOp(2, 16'd99, 16'd13);
      @(negedge clk);
      checkOutput("t4_done",   done_a,   32'h4);
      checkOutput("t4_result", result_a, 32'd143);
      checkOutput("t4_mul_a",  mul_a_a,  32'd11);

      // Lone requester is granted back to back
      setOp(3, 16'd4, 16'd5);
      applyStimulus(0, 4'b1000);
      @(negedge clk);
      checkOutput("t5_grant_a", grant_a, 32'h8);
      @(negedge clk);
      checkOutput("t5_done_a",  done_a,   32'h8);
      checkOutput("t5_result",  result_a, 32'd20);
      @(negedge clk);
      checkOutput("t5_grant_b", grant_a, 32'h8);
      @(negedge clk);
      checkOutput("t5_done_b",  done_a,  32'h8);
      applyStimulus(0, 4'b0000);

      // u_b (MUL_LAT=3): reset in the middle of an operation
      setOp(0, 16'd6, 16'd7);
      applyStimulus(1, 4'b0001);
      @(negedge clk);
      checkOutput("t6_grant", grant_b, 32'h1);
      checkOutput("t6_busy",  busy_b,  32'h1);
      applyStimulus(1, 4'b0000);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      checkOutput("t6_rst_grant", grant_b, 32'h0);
      checkOutput("t6_rst_busy",  busy_b,  32'h0);
      done_seen = done_b;
      repeat (4) begin
         @(negedge clk);
         done_seen = done_seen | done_b;
      end
      checkOutput("t6_no_done", done_seen, 32'h0);
      // Pointer back at 0: requester 0 wins over 1
      applyStimulus(1, 4'b0011);
      @(negedge clk);
      checkOutput("t6_regrant", grant_b, 32'h1);
      applyStimulus(1, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t6_wait_done%0d", k), done_b, 32'h0);
         checkOutput($sformatf("t6_wait_busy%0d", k), busy_b, 32'h1);
      end
      @(negedge clk);
      checkOutput("t6_done",   done_b,   32'h1);
      checkOutput("t6_result", result_b, 32'd42);
`ifdef MUL_ARB_HIGH_WORD_EN
      checkOutput("t6_result_hi", result_hi_b, 32'h0);
`endif

      // u_c (MUL_LAT=4): measure grant-to-done distance and busy length
      setOp(3, 16'd300, 16'd7);
      applyStimulus(2, 4'b1000);
      g_cyc = -1; d_cyc = -1; busy_n = 0;
      gsel = '0; dsel = '0; res_c = '0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (grant_c != 4'b0000 && g_cyc < 0) begin
            g_cyc = c;
            gsel  = grant_c;
            applyStimulus(2, 4'b0000);
         end
         if (done_c != 4'b0000 && d_cyc < 0) begin
            d_cyc = c;
            dsel  = done_c;
            res_c = result_c;
         end
         if (busy_c) busy_n++;
      end
      checkOutput("t7_grant",   gsel,          32'h8);
      checkOutput("t7_done",    dsel,          32'h8);
      checkOutput("t7_latency", d_cyc - g_cyc, 32'd4);
      checkOutput("t7_busy_n",  busy_n,        32'd4);
      checkOutput("t7_result",  res_c,         32'd2100);
`ifdef MUL_ARB_HIGH_WORD_EN
      checkOutput("t7_result_hi", result_hi_c, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
